// File: rtl/alu_pkg.sv
// Shared constants for the two-requester ALU arbiter: opcodes, default width
// and the arbiter FSM state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 5;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [1:0] ST_IDLE_ENC    = 2'b00;
    localparam logic [1:0] ST_ISSUE_ENC   = 2'b01;
    localparam logic [1:0] ST_RESPOND_ENC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_ISSUE   = ST_ISSUE_ENC,
        ST_RESPOND = ST_RESPOND_ENC
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: the pointer names the requester that wins a tie
// and flips to the other requester whenever a grant is taken.
module rr_arb2 (
    input  logic clk,
    input  logic reset_n,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic gnt_id,
    output logic gnt_valid
);

    logic ptr;

    always_comb begin
        gnt_valid = valid0 | valid1;
        gnt_id    = 1'b0;
        if (valid0 && valid1) begin
            gnt_id = ptr;
        end else if (valid1) begin
            gnt_id = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~gnt_id;
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters: accept in
// IDLE, drive the ALU for one ISSUE cycle, hold the tagged result in RESPOND.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic [CNT_W-1:0] done_count
);

    arb_state_t       state, state_nxt;
    logic             gnt_id, gnt_valid, hs;
    logic [WIDTH-1:0] a_p0, b_p0;
    logic             op_p0, id_p0;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .advance   (hs),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Ready is gated by reset_n so both readies drop the instant reset asserts.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        hs         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_valid && reset_n) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    hs         = 1'b1;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE:   state_nxt = ST_RESPOND;
            ST_RESPOND: if (rsp_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accept stage: latch the granted requester's operation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_p0  <= '0;
            b_p0  <= '0;
            op_p0 <= OP_ADD;
            id_p0 <= 1'b0;
        end else if (hs) begin
            a_p0  <= gnt_id ? req1_a  : req0_a;
            b_p0  <= gnt_id ? req1_b  : req0_b;
            op_p0 <= gnt_id ? req1_op : req0_op;
            id_p0 <= gnt_id;
        end
    end

    assign alu_a  = (state == ST_ISSUE) ? a_p0  : '0;
    assign alu_b  = (state == ST_ISSUE) ? b_p0  : '0;
    assign alu_op = (state == ST_ISSUE) ? op_p0 : OP_ADD;

    // Issue stage: capture the ALU result and tag it with the requester id
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= 1'b0;
        end else if (state == ST_ISSUE) begin
            rsp_data  <= alu_result;
            rsp_carry <= alu_carry;
            rsp_id    <= id_p0;
        end
    end

    assign rsp_valid = (state == ST_RESPOND);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            done_count <= done_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: table of single operations, contention,
// backpressure, asynchronous reset and done_count wrap, with a response scoreboard.
module tb_alu_rr_arbiter;
    import alu_pkg::*;

    localparam int W  = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0_valid, req0_ready, req0_op;
    logic [W-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_op;
    logic [W-1:0]  req1_a, req1_b;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic          alu_op, alu_carry;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [W-1:0]  rsp_data;
    logic [CW-1:0] done_count;

    always #5 clk = ~clk;

    // External ALU stand-in
    assign {alu_carry, alu_result} = alu_op ? ({1'b0, alu_a} - {1'b0, alu_b})
                                            : ({1'b0, alu_a} + {1'b0, alu_b});

    alu_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .done_count (done_count)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         carry;
    } rsp_t;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] exp_data;
        logic         exp_carry;
    } vec_t;

    rsp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            rsp_cnt  = 0;
    logic [CW-1:0] exp_done;
    logic          issue_pend, rsp_pend;
    logic [W-1:0]  iss_a, iss_b;
    logic          iss_op;
    logic          hs_seen, hs_id;
    logic [W-1:0]  last_data;
    logic          last_carry, last_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic op);
        int   s;
        logic c;
        if (op == OP_SUB) begin
            s = int'(a) - int'(b);
            c = (a < b);
        end else begin
            s = int'(a) + int'(b);
            c = (s > ((1 << W) - 1));
        end
        return {c, W'(s & ((1 << W) - 1))};
    endfunction

    task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic op);
        logic [W:0] r;
        r = alu_ref(a, b, op);
        exp_q.push_back('{id: id, data: r[W-1:0], carry: r[W]});
        issue_pend = 1'b1;
        iss_a      = a;
        iss_b      = b;
        iss_op     = op;
        hs_seen    = 1'b1;
        hs_id      = id;
    endtask

    // Per-cycle monitor, called at the falling edge
    task automatic sample();
        rsp_t e;
        logic was_issue;
        hs_seen = 1'b0;
        check("done_count", 32'(done_count), 32'(exp_done));
        check("ready_overlap", 32'(req0_ready & req1_ready), 0);
        if (issue_pend) begin
            check("alu_a", 32'(alu_a), 32'(iss_a));
            check("alu_b", 32'(alu_b), 32'(iss_b));
            check("alu_op", 32'(alu_op), 32'(iss_op));
            check("rsp_early", 32'(rsp_valid), 0);
            check("ready_in_issue", 32'({req0_ready, req1_ready}), 0);
        end else begin
            check("alu_idle_zero", 32'({alu_a, alu_b, alu_op}), 0);
        end
        if (rsp_pend) check("rsp_valid_latency", 32'(rsp_valid), 1);
        if (rsp_valid) begin
            check("ready_in_respond", 32'({req0_ready, req1_ready}), 0);
            check("rsp_expected_pending", 32'(exp_q.size() != 0), 1);
        end
        was_issue  = issue_pend;
        issue_pend = 1'b0;
        rsp_pend   = was_issue;
        if (req0_valid && req0_ready) push_exp(1'b0, req0_a, req0_b, req0_op);
        if (req1_valid && req1_ready) push_exp(1'b1, req1_a, req1_b, req1_op);
        if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
            last_id    = rsp_id;
            last_data  = rsp_data;
            last_carry = rsp_carry;
            rsp_cnt++;
            exp_done = exp_done + CW'(1);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 0);
        check("rst_alu", 32'({alu_a, alu_b, alu_op}), 0);
        check("rst_done_count", 32'(done_count), 0);
        exp_q.delete();
        issue_pend = 1'b0;
        rsp_pend   = 1'b0;
        exp_done   = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic op);
        if (!id) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic wait_hs(output int waited);
        waited = 0;
        tick();
        while (!hs_seen && waited < 20) begin
            waited++;
            tick();
        end
        check("handshake_seen", 32'(hs_seen), 1);
    endtask

    task automatic wait_rsp(input int target);
        int t;
        t = 0;
        while (rsp_cnt < target && t < 1000) begin
            t++;
            tick();
        end
        check("rsp_arrived", 32'(rsp_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        int   w, n;
        logic [CW-1:0] d0;

        reset_n = 1'b1;
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, OP_ADD);
        set_req(1'b1, 1'b0, '0, '0, OP_ADD);
        exp_done = '0; issue_pend = 1'b0; rsp_pend = 1'b0;
        hs_seen = 1'b0; hs_id = 1'b0;
        last_data = '0; last_carry = 1'b0; last_id = 1'b0;
        #2;
        apply_reset();

        vt[0] = '{1'b0, 5'b11100, 5'b00011, OP_ADD, 5'b11111, 1'b0};
        vt[1] = '{1'b1, 5'b10100, 5'b00010, OP_SUB, 5'b10010, 1'b0};
        vt[2] = '{1'b1, 5'b11100, 5'b00100, OP_SUB, 5'b11000, 1'b0};
        vt[3] = '{1'b0, 5'b11111, 5'b00001, OP_ADD, 5'b00000, 1'b1};
        vt[4] = '{1'b1, 5'b00001, 5'b00010, OP_SUB, 5'b11111, 1'b1};
        vt[5] = '{1'b0, 5'b10000, 5'b10000, OP_ADD, 5'b00000, 1'b1};
        vt[6] = '{1'b0, 5'b00101, 5'b00101, OP_SUB, 5'b00000, 1'b0};
        vt[7] = '{1'b1, 5'b01010, 5'b00101, OP_ADD, 5'b01111, 1'b0};

        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = rsp_cnt;
            set_req(vt[i].id, 1'b1, vt[i].a, vt[i].b, vt[i].op);
            wait_hs(w);
            check("vec_grant_latency", 32'(w), 0);
            check("vec_grant_id", 32'(hs_id), 32'(vt[i].id));
            set_req(vt[i].id, 1'b0, '0, '0, OP_ADD);
            wait_rsp(n + 1);
            check("vec_rsp_id", 32'(last_id), 32'(vt[i].id));
            check("vec_rsp_data", 32'(last_data), 32'(vt[i].exp_data));
            check("vec_rsp_carry", 32'(last_carry), 32'(vt[i].exp_carry));
            check("vec_done_count", 32'(done_count), 32'(i + 1));
        end

        // Contention from a fresh reset: strict alternation starting at 0
        apply_reset();
        n = rsp_cnt;
        set_req(1'b0, 1'b1, 5'd3, 5'd9, OP_ADD);
        set_req(1'b1, 1'b1, 5'd20, 5'd7, OP_SUB);
        for (int k = 0; k < 8; k++) begin
            wait_hs(w);
            check("contention_grant", 32'(hs_id), 32'(k % 2));
            check("contention_wait", 32'(w), (k == 0) ? 0 : 2);
            set_req(hs_id, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
        end
        set_req(1'b0, 1'b0, '0, '0, OP_ADD);
        set_req(1'b1, 1'b0, '0, '0, OP_ADD);
        wait_rsp(n + 8);

        // Backpressure: response held five cycles, competing request waits
        rsp_ready = 1'b0;
        n  = rsp_cnt;
        d0 = done_count;
        set_req(1'b0, 1'b1, 5'b00110, 5'b00111, OP_ADD);
        wait_hs(w);
        set_req(1'b0, 1'b0, '0, '0, OP_ADD);
        set_req(1'b1, 1'b1, 5'b01000, 5'b00011, OP_SUB);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 1);
            check("bp_rsp_hold", 32'({rsp_id, rsp_data, rsp_carry}), 32'({1'b0, 5'b01101, 1'b0}));
            check("bp_done_hold", 32'(done_count), 32'(d0));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        wait_hs(w);
        check("bp_next_grant_latency", 32'(w), 0);
        check("bp_next_grant_id", 32'(hs_id), 1);
        set_req(1'b1, 1'b0, '0, '0, OP_ADD);
        wait_rsp(n + 2);

        // Reset during ISSUE: no response, pointer back to requester 0
        n = rsp_cnt;
        set_req(1'b0, 1'b1, 5'd1, 5'd1, OP_ADD);
        wait_hs(w);
        set_req(1'b0, 1'b0, '0, '0, OP_ADD);
        wait_rsp(n + 1);
        set_req(1'b0, 1'b1, 5'd4, 5'd2, OP_ADD);
        set_req(1'b1, 1'b1, 5'd9, 5'd5, OP_SUB);
        wait_hs(w);
        check("midop_grant_ptr", 32'(hs_id), 1);
        set_req(1'b0, 1'b0, '0, '0, OP_ADD);
        set_req(1'b1, 1'b0, '0, '0, OP_ADD);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            check("midop_no_rsp", 32'(rsp_valid), 0);
            tick();
        end
        n = rsp_cnt;
        set_req(1'b0, 1'b1, 5'd6, 5'd1, OP_SUB);
        set_req(1'b1, 1'b1, 5'd2, 5'd2, OP_ADD);
        wait_hs(w);
        check("midop_ptr_restart", 32'(hs_id), 0);
        set_req(1'b0, 1'b0, '0, '0, OP_ADD);
        set_req(1'b1, 1'b0, '0, '0, OP_ADD);
        wait_rsp(n + 1);

        // done_count wrap after 256 completions
        apply_reset();
        n = rsp_cnt;
        set_req(1'b0, 1'b1, 5'd17, 5'd30, OP_ADD);
        set_req(1'b1, 1'b1, 5'd5, 5'd12, OP_SUB);
        for (int k = 0; k < 256; k++) begin
            wait_hs(w);
        end
        set_req(1'b0, 1'b0, '0, '0, OP_ADD);
        set_req(1'b1, 1'b0, '0, '0, OP_ADD);
        wait_rsp(n + 256);
        check("wrap_done_zero", 32'(done_count), 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
